axi_hp_dma_writer: RTL and testbench
====================================

// Module: axi_hp_dma_writer
// PURPOSE
// - Streams 64-bit data from a local valid/ready source into memory through a Zynq AXI HP port.
// - Companion write-side engine to the HP DMA read path; same control-port style.
// - Issues fixed 16-beat INCR bursts of 128 B and tracks AW, W and B completion.
// - Reports busy status and a cycle count for bandwidth measurement.
// PARAMETERS
// - DWIDTH  64  data width in bits; only 64 is supported (awsize fixed to dword).
// PORTS
// - clk        in   1       clock; all logic on posedge
// - rstn       in   1       asynchronous, active-low reset
// - m          ifc  -       axi_ifc.writer master (AW/W/B channels)
// - txn_addr   in   32      start byte address; bits 6:0 ignored
// - txn_count  in   32      byte count; bits 6:0 ignored, bits 22:7 = bursts
// - txn_start  in   1       start request; sampled only while idle
// - txn_busy   out  1       transfer in progress
// - cyc_count  out  32      clk cycles elapsed since the accepted start
// - data       in   DWIDTH  write data from source
// - valid      in   1       source data valid
// - ready      out  1       beat accepted when valid & ready
// BEHAVIOUR
// - Constants: awid=0, awlen=15, awsize=3'b011, awburst=INCR, awlock=0, awcache=0, wstrb=all ones, bready=1.
// - Reset (rstn low, async): IDLE; txn_busy=0, cyc_count=0, awvalid=0, wvalid=0, ready=0, all counters=0.
// - Counters:
//   - awcount[15:0]: bursts left to address.
//   - wcount[19:0]: beats left to write.
//   - beat[3:0]: position within the current burst.
//   - bcount[15:0]: B responses outstanding.
// - FSM states: IDLE, RUN, WAITB.
//   - IDLE, txn_start=1: on the next edge, awaddr={txn_addr[31:7],7'd0}, awcount=bcount=txn_count[22:7], wcount={txn_count[22:7],4'd0}, beat=0, cyc_count=0, txn_busy=1; go to RUN.
//   - RUN: when awcount==0 and wcount==0, go to WAITB.
//   - WAITB: when bcount==0, txn_busy=0 on the next edge; go to IDLE.
//   - Zero-count start: passes RUN and WAITB with no AXI traffic; busy for exactly 2 cycles.
// - AW channel: awvalid=(awcount!=0). On awvalid&awready: awcount-1, awaddr+128. awaddr/awvalid stay stable while stalled.
// - W channel: wvalid=valid&(wcount!=0); ready=m.wready&(wcount!=0); wdata=data combinationally.
// - On each W beat: wcount-1, beat+1 (wraps 15->0). wlast=(beat==15).
// - W may lead AW (HP port accepts); no ordering interlock unless the macro below is defined.
// - B channel: each bvalid decrements bcount; bresp is ignored unless the macro below is defined.
// - Simultaneous events: AW, W and B handshakes in one cycle each update their own counter independently.
// - cyc_count increments every cycle while txn_busy=1 and holds after completion.
// - txn_start while busy is ignored, not queued.
// - Reset mid-transfer: immediate abort; AXI handshakes may break. Use only for system reset.
// - bcount underflow (unexpected B) is a protocol error; counter saturates at 0.
// CONFIGURATION
// - Macro AXI_DMA_WRITER_ERR_EN.
// - Defined:
//   - Adds output txn_error (1 bit, reset 0), cleared on the accepted txn_start.
//   - txn_error is set sticky on any B with bresp!=2'b00.
//   - Also gates W so beats issued never exceed 16 x bursts addressed (no W-before-AW).
// - Undefined: no txn_error port; bresp ignored; W ungated.
// TESTING
// - Single burst: addr=0x1000_0000, count=128, source always valid, wready/awready=1 -> one AW at 0x1000_0000, 16 beats, wlast on beat 16, busy drops after B.
// - Multi-burst: addr=0x1000_0047, count=0x400 -> 8 AWs at 0x1000_0000 + n*0x80, 128 beats, 8 wlast pulses.
// - Backpressure: random awready/wready/bvalid delays and random source valid -> data order preserved, no beats lost or duplicated, cyc_count equals measured busy cycles.
// - Zero count: count=0x7F -> no awvalid/wvalid, txn_busy high 2 cycles; a start during busy is ignored.
// - Reset abort: rstn low mid-burst -> all outputs 0 in the same cycle; a new 128-byte transfer then completes normally.
// - ERR_EN: bresp=2'b10 on burst 3 of 4 -> txn_error=1 after that B, held until the next start; W never leads AW.

Source files
------------

// File: rtl/axi_hp_dma_writer_if.sv
// -----------------------------------------------------------------------------
// axi_ifc
// AXI3 write-side bundle (AW/W/B) for a Zynq HP slave port.
//
// Modports:
//   writer : master side (drives AW/W, bready; observes awready/wready/B)
//   memory : slave side  (mirror of writer)
// -----------------------------------------------------------------------------
interface axi_ifc #(
    parameter int DWIDTH = 64
);
    logic [5:0]          awid;
    logic [31:0]         awaddr;
    logic [3:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic [1:0]          awlock;
    logic [3:0]          awcache;
    logic                awvalid;
    logic                awready;

    logic [DWIDTH-1:0]   wdata;
    logic [DWIDTH/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;

    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    modport writer (
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready
    );

    modport memory (
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/axi_hp_dma_writer.sv
// -----------------------------------------------------------------------------
// axi_hp_dma_writer
// Streams 64-bit words from a valid/ready source into memory through a Zynq
// AXI HP port using fixed 16-beat INCR bursts (128 B each). Tracks AW, W and
// B completion independently and reports busy plus an elapsed-cycle count.
//
// Ports:
//   clk, rstn        clock / asynchronous active-low reset
//   m                axi_ifc.writer master (AW/W/B)
//   txn_addr         start byte address (bits 6:0 ignored)
//   txn_count        byte count (bits 22:7 = number of bursts, rest ignored)
//   txn_start        start request, sampled only while idle
//   txn_busy         transfer in progress
//   cyc_count        cycles elapsed since the accepted start (holds at end)
//   data/valid/ready source stream; a beat moves when valid & ready
//   txn_error        (AXI_DMA_WRITER_ERR_EN only) sticky non-OKAY B response
//
// Build option: define AXI_DMA_WRITER_ERR_EN to add txn_error, bresp checking
// and a W gate that keeps written beats within the bursts already addressed.
// -----------------------------------------------------------------------------
module axi_hp_dma_writer #(
    parameter int DWIDTH = 64
) (
    input  logic              clk,
    input  logic              rstn,
    axi_ifc.writer            m,
    input  logic [31:0]       txn_addr,
    input  logic [31:0]       txn_count,
    input  logic              txn_start,
    output logic              txn_busy,
    output logic [31:0]       cyc_count,
    input  logic [DWIDTH-1:0] data,
    input  logic              valid,
    output logic              ready
`ifdef AXI_DMA_WRITER_ERR_EN
    ,
    output logic              txn_error
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        WAITB = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] awaddr_q, awaddr_d;
    logic [15:0] awcount_q, awcount_d;
    logic [19:0] wcount_q, wcount_d;
    logic [3:0]  beat_q, beat_d;
    logic [15:0] bcount_q, bcount_d;
    logic        busy_q, busy_d;
    logic [31:0] cyc_q, cyc_d;
`ifdef AXI_DMA_WRITER_ERR_EN
    logic        err_q, err_d;
`endif

    logic aw_hs;
    logic w_ok;
    logic w_hs;
    logic b_hs;

`ifdef AXI_DMA_WRITER_ERR_EN
    // Beats written so far stay within 16 x bursts addressed. Since both
    // counters start at bursts and 16*bursts, that reduces to
    // wcount > 16*awcount on the live counters.
    assign w_ok = (wcount_q > {awcount_q, 4'd0});
`else
    assign w_ok = (wcount_q != 20'd0);
`endif

    assign aw_hs = (awcount_q != 16'd0) & m.awready;
    assign w_hs  = valid & m.wready & w_ok;
    assign b_hs  = m.bvalid;            // bready is tied high

    always_comb begin
        state_d   = state_q;
        awaddr_d  = awaddr_q;
        awcount_d = awcount_q;
        wcount_d  = wcount_q;
        beat_d    = beat_q;
        bcount_d  = bcount_q;
        busy_d    = busy_q;
        cyc_d     = cyc_q;
`ifdef AXI_DMA_WRITER_ERR_EN
        err_d     = err_q;
`endif

        // AW, W and B each move their own counter; they never interact.
        if (aw_hs) begin
            awcount_d = awcount_q - 16'd1;
            awaddr_d  = awaddr_q + 32'd128;
        end
        if (w_hs) begin
            wcount_d = wcount_q - 20'd1;
            beat_d   = beat_q + 4'd1;
        end
        // An unexpected B must not wrap the counter.
        if (b_hs && (bcount_q != 16'd0)) begin
            bcount_d = bcount_q - 16'd1;
        end
`ifdef AXI_DMA_WRITER_ERR_EN
        if (b_hs && (m.bresp != 2'b00)) begin
            err_d = 1'b1;
        end
`endif
        if (busy_q) begin
            cyc_d = cyc_q + 32'd1;
        end

        case (state_q)
            IDLE: begin
                if (txn_start) begin
                    awaddr_d  = {txn_addr[31:7], 7'd0};
                    awcount_d = txn_count[22:7];
                    bcount_d  = txn_count[22:7];
                    wcount_d  = {txn_count[22:7], 4'd0};
                    beat_d    = 4'd0;
                    cyc_d     = 32'd0;
                    busy_d    = 1'b1;
`ifdef AXI_DMA_WRITER_ERR_EN
                    err_d     = 1'b0;
`endif
                    state_d   = RUN;
                end
            end
            RUN: begin
                if ((awcount_q == 16'd0) && (wcount_q == 20'd0)) begin
                    state_d = WAITB;
                end
            end
            WAITB: begin
                if (bcount_q == 16'd0) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            awaddr_q  <= 32'd0;
            awcount_q <= 16'd0;
            wcount_q  <= 20'd0;
            beat_q    <= 4'd0;
            bcount_q  <= 16'd0;
            busy_q    <= 1'b0;
            cyc_q     <= 32'd0;
`ifdef AXI_DMA_WRITER_ERR_EN
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            awaddr_q  <= awaddr_d;
            awcount_q <= awcount_d;
            wcount_q  <= wcount_d;
            beat_q    <= beat_d;
            bcount_q  <= bcount_d;
            busy_q    <= busy_d;
            cyc_q     <= cyc_d;
`ifdef AXI_DMA_WRITER_ERR_EN
            err_q     <= err_d;
`endif
        end
    end

    // Fixed burst shape: 16 beats of 8 bytes, INCR, normal access.
    assign m.awid    = 6'd0;
    assign m.awaddr  = awaddr_q;
    assign m.awlen   = 4'd15;
    assign m.awsize  = 3'b011;
    assign m.awburst = 2'b01;
    assign m.awlock  = 2'b00;
    assign m.awcache = 4'b0000;
    assign m.awvalid = (awcount_q != 16'd0);

    assign m.wdata   = data;
    assign m.wstrb   = '1;
    assign m.wlast   = (beat_q == 4'd15);
    assign m.wvalid  = valid & w_ok;
    assign m.bready  = 1'b1;

    assign ready     = m.wready & w_ok;
    assign txn_busy  = busy_q;
    assign cyc_count = cyc_q;

`ifdef AXI_DMA_WRITER_ERR_EN
    assign txn_error = err_q;

    logic unused_bits;
    assign unused_bits = ^{txn_addr[6:0], txn_count[31:23], txn_count[6:0]};
`else
    logic unused_bits;
    assign unused_bits = ^{txn_addr[6:0], txn_count[31:23], txn_count[6:0], m.bresp};
`endif

endmodule

// File: tb/tb_axi_hp_dma_writer.sv
module tb_axi_hp_dma_writer;

    logic        clk;
    logic        rstn;
    logic [31:0] txn_addr;
    logic [31:0] txn_count;
    logic        txn_start;
    logic        txn_busy;
    logic [31:0] cyc_count;
    logic [63:0] data;
    logic        valid;
    logic        ready;
`ifdef AXI_DMA_WRITER_ERR_EN
    logic        txn_error;
`endif

    axi_ifc #(.DWIDTH(64)) m_if ();

    axi_hp_dma_writer #(.DWIDTH(64)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .m         (m_if),
        .txn_addr  (txn_addr),
        .txn_count (txn_count),
        .txn_start (txn_start),
        .txn_busy  (txn_busy),
        .cyc_count (cyc_count),
        .data      (data),
        .valid     (valid),
        .ready     (ready)
`ifdef AXI_DMA_WRITER_ERR_EN
        ,
        .txn_error (txn_error)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] d;
        logic        last;
    } beat_t;

    // Scoreboard queues filled when a transfer is issued.
    logic [31:0] exp_aw[$];
    beat_t       exp_w[$];
    logic [63:0] src_q[$];

    int n_pass  = 0;
    int n_total = 0;

    // Event flags written by the monitor at negedge, consumed by the driver.
    logic w_fire = 1'b0;
    logic b_fire = 1'b0;

    int aw_seen     = 0;
    int wlast_seen  = 0;
    int w_beats     = 0;
    int b_sent      = 0;
    int busy_cycles = 0;
    int cur_bursts  = 0;
    int err_burst   = -1;
    bit rnd         = 1'b0;
    logic exp_err   = 1'b0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endfunction

    // Monitor: pops expectations whenever the DUT completes a handshake.
    always @(negedge clk) begin
        beat_t e;
        logic  aw_f;
        aw_f   = m_if.awvalid && m_if.awready;
        w_fire = valid && ready;
        b_fire = m_if.bvalid && m_if.bready;
        if (txn_busy) busy_cycles++;
        if (w_fire) begin
            chk("w_handshake", 64'({m_if.wvalid, m_if.wready, m_if.wstrb}), 64'h3FF);
`ifdef AXI_DMA_WRITER_ERR_EN
            chk("w_after_aw", 64'(w_beats < 16 * aw_seen), 64'd1);
`endif
            if (exp_w.size() == 0) begin
                chk("w_unexpected", 64'd1, 64'd0);
            end else begin
                e = exp_w.pop_front();
                chk("wdata", m_if.wdata, e.d);
                chk("wlast", 64'(m_if.wlast), 64'(e.last));
            end
            w_beats++;
            if (m_if.wlast) wlast_seen++;
        end
        if (aw_f) begin
            if (exp_aw.size() == 0) begin
                chk("aw_unexpected", 64'd1, 64'd0);
            end else begin
                chk("awaddr", 64'(m_if.awaddr), 64'(exp_aw.pop_front()));
                chk("aw_attr", 64'({m_if.awid, m_if.awlen, m_if.awsize, m_if.awburst,
                                    m_if.awlock, m_if.awcache}),
                    64'({6'd0, 4'd15, 3'b011, 2'b01, 2'b00, 4'b0000}));
            end
            aw_seen++;
        end
`ifdef AXI_DMA_WRITER_ERR_EN
        if (b_fire) begin
            chk("txn_error_pre_b", 64'(txn_error), 64'(exp_err));
            if (m_if.bresp != 2'b00) exp_err = 1'b1;
        end
`endif
    end

    // One clock of stimulus: consume last cycle's handshakes, then redrive.
    task automatic tick();
        int owed;
        @(posedge clk);
        #1;
        if (w_fire && src_q.size() > 0) void'(src_q.pop_front());
        if (b_fire) begin
            b_sent++;
            m_if.bvalid = 1'b0;
        end
        m_if.awready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
        m_if.wready  = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
        valid = (src_q.size() > 0) && (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
        data  = (src_q.size() > 0) ? src_q[0] : 64'd0;
        owed  = ((aw_seen < wlast_seen) ? aw_seen : wlast_seen) - b_sent;
        if (!m_if.bvalid && owed > 0 && (!rnd || $urandom_range(0, 2) == 0)) begin
            m_if.bvalid = 1'b1;
            m_if.bresp  = (b_sent == err_burst) ? 2'b10 : 2'b00;
        end
    endtask

    // Reference model: expected bursts and beats from address/count alone.
    task automatic issue(input logic [31:0] addr, input logic [31:0] count);
        logic [31:0] base;
        beat_t       b;
        cur_bursts = int'(count[22:7]);
        base = addr & 32'hFFFF_FF80;
        for (int n = 0; n < cur_bursts; n++) exp_aw.push_back(base + 32'(n * 128));
        for (int i = 0; i < cur_bursts * 16; i++) begin
            b.d    = {$urandom, $urandom};
            b.last = ((i % 16) == 15);
            exp_w.push_back(b);
            src_q.push_back(b.d);
        end
        aw_seen     = 0;
        wlast_seen  = 0;
        w_beats     = 0;
        b_sent      = 0;
        busy_cycles = 0;
        exp_err     = 1'b0;
        txn_addr    = addr;
        txn_count   = count;
        txn_start   = 1'b1;
        tick();
        txn_start   = 1'b0;
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 6000; i++) begin
            if (!txn_busy) break;
            tick();
        end
        chk({name, "_timeout"}, 64'(txn_busy), 64'd0);
        chk({name, "_aw_left"}, 64'(exp_aw.size()), 64'd0);
        chk({name, "_w_left"}, 64'(exp_w.size()), 64'd0);
        chk({name, "_b_count"}, 64'(b_sent), 64'(cur_bursts));
        chk({name, "_cyc"}, 64'(cyc_count), 64'(busy_cycles));
    endtask

    initial begin
        rstn         = 1'b0;
        txn_addr     = '0;
        txn_count    = '0;
        txn_start    = 1'b0;
        data         = '0;
        valid        = 1'b0;
        m_if.awready = 1'b0;
        m_if.wready  = 1'b0;
        m_if.bvalid  = 1'b0;
        m_if.bresp   = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_state", 64'({txn_busy, m_if.awvalid, m_if.wvalid, ready}), 64'd0);
        chk("rst_cyc", 64'(cyc_count), 64'd0);
        rstn = 1'b1;
        tick();

        // Single burst at full speed.
        rnd = 1'b0;
        issue(32'h1000_0000, 32'd128);
        wait_done("single");
        chk("single_wlast", 64'(wlast_seen), 64'd1);

        // Multi-burst with unaligned start address.
        issue(32'h1000_0047, 32'h400);
        wait_done("multi");
        chk("multi_wlast", 64'(wlast_seen), 64'd8);
        chk("multi_beats", 64'(w_beats), 64'd128);

        // Randomized backpressure on every channel and on the source.
        rnd = 1'b1;
        for (int t = 0; t < 6; t++) begin
            int nb;
            nb = $urandom_range(1, 5);
            issue($urandom, ($urandom & 32'hFF80_0000) | 32'(nb << 7) | 32'($urandom_range(0, 127)));
            wait_done("random");
            chk("random_beats", 64'(w_beats), 64'(nb * 16));
        end

        // Zero-count start; restarts while busy (RUN and WAITB) are ignored.
        rnd = 1'b0;
        issue(32'h3000_0000, 32'h7F);
        txn_count = 32'h400;
        txn_start = 1'b1;
        tick();
        tick();
        txn_start = 1'b0;
        wait_done("zero");
        chk("zero_busy_cycles", 64'(busy_cycles), 64'd2);
        repeat (3) tick();
        chk("zero_idle_after", 64'(txn_busy), 64'd0);

        // Reset in the middle of a transfer aborts at once.
        issue(32'h1000_0000, 32'h400);
        repeat (20) tick();
        #1;
        rstn = 1'b0;
        #1;
        chk("abort_outputs", 64'({txn_busy, m_if.awvalid, m_if.wvalid, ready}), 64'd0);
        chk("abort_cyc", 64'(cyc_count), 64'd0);
        src_q.delete();
        exp_aw.delete();
        exp_w.delete();
        valid       = 1'b0;
        m_if.bvalid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        tick();
        issue(32'h1000_0000, 32'd128);
        wait_done("after_abort");

`ifdef AXI_DMA_WRITER_ERR_EN
        // Error response on the third of four bursts.
        rnd       = 1'b1;
        err_burst = 2;
        issue(32'h2000_0000, 32'h200);
        wait_done("err");
        chk("err_sticky", 64'(txn_error), 64'd1);
        repeat (3) tick();
        chk("err_held", 64'(txn_error), 64'd1);
        err_burst = -1;
        issue(32'h2000_0000, 32'd128);
        chk("err_cleared", 64'(txn_error), 64'd0);
        wait_done("err_next");
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
